mem_access_ctrl: RTL and testbench

Load/store access controller between the MEM pipeline stage and `data_ram`. Accepts one load or store per handshake. Issues aligned accesses to `data_ram` as a single Byte, Half or Word beat, and splits misaligned accesses into consecutive byte beats. Assembles and sign- or zero-extends load data and returns a one-cycle response while holding `req_ready` low for the duration.

---
 rtl/mem_access_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - load/store access controller between the MEM stage and data_ram
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake from MEM (ready only while idle)
//   req_we, req_funct3         store/load select and RV32I access type
//   req_addr, req_wdata        byte address (upper bits above AW ignored), right-aligned store data
//   resp_valid                 one-cycle completion pulse, no backpressure
//   resp_rdata, resp_err       extended load data / illegal funct3 flag
//   ram_ce, ram_we, ram_re     data_ram chip enable and strobes
//   ram_wvalid_bit/rvalid_bit  beat size: 01 byte, 10 half, 11 word
//   ram_waddr/raddr, ram_wdata beat address and right-aligned write data
//   ram_rdata                  data_ram combinational read data
module mem_access_ctrl #(
   parameter int AW = 17
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [2:0]    req_funct3,
   input  logic [31:0]   req_addr,
   input  logic [31:0]   req_wdata,
   output logic          resp_valid,
   output logic [31:0]   resp_rdata,
   output logic          resp_err,
   output logic          ram_ce,
   output logic          ram_we,
   output logic          ram_re,
   output logic [1:0]    ram_wvalid_bit,
   output logic [1:0]    ram_rvalid_bit,
   output logic [AW-1:0] ram_waddr,
   output logic [AW-1:0] ram_raddr,
   output logic [31:0]   ram_wdata,
   input  logic [31:0]   ram_rdata
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_RESP = 2'd2} state_t;

   state_t        r_state;
   state_t        w_next;
   logic          r_we;
   logic          r_err;
   logic [2:0]    r_funct3;
   logic [AW-1:0] r_addr;
   logic [31:0]   r_wdata;
   logic [31:0]   r_asm;
   logic [1:0]    r_beat;

   logic          w_accept;
   logic          w_legal;
   logic          w_misalign;
   logic          w_last;
   logic [1:0]    w_size;
   logic [1:0]    w_beat_size;
   logic [AW-1:0] w_beat_addr;
   logic [31:0]   w_mask;
   logic [31:0]   w_wshift;
   logic [31:0]   w_ext;

   assign w_accept = req_valid && (r_state == S_IDLE);

   always_comb begin
      w_legal = 1'b0;
      if (req_we) begin
         w_legal = (req_funct3[2] == 1'b0) && (req_funct3[1:0] != 2'b11);
      end else begin
         case (req_funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
            default:                                w_legal = 1'b0;
         endcase
      end
   end

   assign w_size     = r_funct3[1:0];
   assign w_misalign = ((w_size == 2'b01) && r_addr[0]) ||
                       ((w_size == 2'b10) && (r_addr[1:0] != 2'b00));
   // Misaligned halves take 2 byte beats, misaligned words take 4.
   assign w_last      = !w_misalign || ((w_size == 2'b01) ? (r_beat == 2'd1) : (r_beat == 2'd3));
   assign w_beat_addr = r_addr + AW'(r_beat);
   assign w_beat_size = w_misalign ? 2'b01 : (w_size + 2'b01);
   assign w_wshift    = r_wdata >> {r_beat, 3'b000};

   always_comb begin
      case (w_size)
         2'b00:   w_mask = 32'h0000_00FF;
         2'b01:   w_mask = 32'h0000_FFFF;
         default: w_mask = 32'hFFFF_FFFF;
      endcase
   end

   always_comb begin
      case (r_funct3)
         3'b000:  w_ext = {{24{r_asm[7]}}, r_asm[7:0]};
         3'b001:  w_ext = {{16{r_asm[15]}}, r_asm[15:0]};
         3'b010:  w_ext = r_asm;
         3'b100:  w_ext = {24'd0, r_asm[7:0]};
         3'b101:  w_ext = {16'd0, r_asm[15:0]};
         default: w_ext = 32'd0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_we     <= 1'b0;
         r_err    <= 1'b0;
         r_funct3 <= 3'd0;
         r_addr   <= '0;
         r_wdata  <= 32'd0;
         r_asm    <= 32'd0;
         r_beat   <= 2'd0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_we     <= req_we;
            r_err    <= !w_legal;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr[AW-1:0];
            r_wdata  <= req_wdata;
            r_asm    <= 32'd0;
            r_beat   <= 2'd0;
         end else if (r_state == S_ACCESS) begin
            if (!r_we) begin
               if (w_misalign) begin
                  r_asm[{r_beat, 3'b000} +: 8] <= ram_rdata[7:0];
               end else begin
                  r_asm <= ram_rdata & w_mask;
               end
            end
            r_beat <= w_last ? 2'd0 : (r_beat + 2'd1);
         end
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (req_valid) w_next = w_legal ? S_ACCESS : S_RESP;
         S_ACCESS: if (w_last) w_next = S_RESP;
         S_RESP:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // ram_ce follows reset directly so it drops the instant reset asserts.
   assign ram_ce = rst_n;

   always_comb begin
      req_ready      = (r_state == S_IDLE);
      resp_valid     = 1'b0;
      resp_err       = 1'b0;
      resp_rdata     = 32'd0;
      ram_we         = 1'b0;
      ram_re         = 1'b0;
      ram_wvalid_bit = 2'b00;
      ram_rvalid_bit = 2'b00;
      ram_waddr      = '0;
      ram_raddr      = '0;
      ram_wdata      = 32'd0;
      if (r_state == S_RESP) begin
         resp_valid = 1'b1;
         resp_err   = r_err;
         resp_rdata = (r_we || r_err) ? 32'd0 : w_ext;
      end
      if (r_state == S_ACCESS) begin
         ram_we         = r_we;
         ram_re         = !r_we;
         ram_wvalid_bit = w_beat_size;
         ram_rvalid_bit = w_beat_size;
         ram_waddr      = w_beat_addr;
         ram_raddr      = w_beat_addr;
         if (r_we) begin
            ram_wdata = w_misalign ? {24'd0, w_wshift[7:0]} : (r_wdata & w_mask);
         end
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl with a behavioural data_ram
module tb_mem_access_ctrl;

   localparam int AW = 17;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_we = 1'b0;
   logic [2:0]    req_funct3 = 3'd0;
   logic [31:0]   req_addr = 32'd0;
   logic [31:0]   req_wdata = 32'd0;
   logic          resp_valid;
   logic [31:0]   resp_rdata;
   logic          resp_err;
   logic          ram_ce;
   logic          ram_we;
   logic          ram_re;
   logic [1:0]    ram_wvalid_bit;
   logic [1:0]    ram_rvalid_bit;
   logic [AW-1:0] ram_waddr;
   logic [AW-1:0] ram_raddr;
   logic [31:0]   ram_wdata;
   logic [31:0]   ram_rdata;

   mem_access_ctrl #(.AW(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .ram_ce(ram_ce), .ram_we(ram_we), .ram_re(ram_re),
      .ram_wvalid_bit(ram_wvalid_bit), .ram_rvalid_bit(ram_rvalid_bit),
      .ram_waddr(ram_waddr), .ram_raddr(ram_raddr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural data_ram: little-endian bytes, addresses wrap in AW bits.
   bit [7:0] mem [0:(1<<AW)-1];
   logic [AW-1:0] ra1, ra2, ra3, wa1, wa2, wa3;
   always_comb begin
      ra1 = ram_raddr + 17'd1;
      ra2 = ram_raddr + 17'd2;
      ra3 = ram_raddr + 17'd3;
      ram_rdata = 32'd0;
      if (ram_re) begin
         case (ram_rvalid_bit)
            2'b01:   ram_rdata = {24'd0, mem[ram_raddr]};
            2'b10:   ram_rdata = {16'd0, mem[ra1], mem[ram_raddr]};
            2'b11:   ram_rdata = {mem[ra3], mem[ra2], mem[ra1], mem[ram_raddr]};
            default: ram_rdata = 32'd0;
         endcase
      end
   end
   always @(posedge clk) begin
      wa1 = ram_waddr + 17'd1;
      wa2 = ram_waddr + 17'd2;
      wa3 = ram_waddr + 17'd3;
      if (ram_we) begin
         mem[ram_waddr] <= ram_wdata[7:0];
         if (ram_wvalid_bit[1]) mem[wa1] <= ram_wdata[15:8];
         if (ram_wvalid_bit == 2'b11) begin
            mem[wa2] <= ram_wdata[23:16];
            mem[wa3] <= ram_wdata[31:24];
         end
      end
   end

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } resp_t;
   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   wdata;
      logic          we;
      logic [1:0]    sz;
   } beat_t;

   resp_t rq[$];
   beat_t bq[$];
   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
   endtask

   // Monitor: pops expected responses and beats whenever the DUT presents them.
   always @(negedge clk) begin
      if (rst_n) begin
         if (resp_valid) begin
            if (rq.size() == 0) begin
               chk("resp_unexpected", 32'd1, 32'd0);
            end else begin
               resp_t e;
               e = rq.pop_front();
               chk("resp_rdata", resp_rdata, e.rdata);
               chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
               chk("resp_latency", cyc, e.cyc);
            end
         end
         if (ram_we || ram_re) begin
            if (bq.size() == 0) begin
               chk("beat_unexpected", {ram_waddr, 13'd0, ram_we, ram_re}, 32'd0);
            end else begin
               beat_t b;
               b = bq.pop_front();
               chk("beat_strobes", {30'd0, ram_we, ram_re}, {30'd0, b.we, !b.we});
               chk("beat_addr", {15'd0, ram_waddr}, {15'd0, b.addr});
               chk("beat_raddr", {15'd0, ram_raddr}, {15'd0, b.addr});
               chk("beat_size", {28'd0, ram_wvalid_bit, ram_rvalid_bit}, {28'd0, b.sz, b.sz});
               if (b.we) chk("beat_wdata", ram_wdata, b.wdata);
               chk("ram_ce", {31'd0, ram_ce}, 32'd1);
            end
         end
      end
   end

   task automatic issue(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                        input bit [31:0] wd, input bit [31:0] exp_rd, input bit exp_err,
                        input int lat, input int keep, input bit do_resp);
      int t;
      int acc;
      bit illegal;
      bit mis;
      bit [1:0] sz;
      int n;
      bit [31:0] mask;
      bit [31:0] sh;
      beat_t b;
      resp_t r;
      t = 0;
      @(negedge clk);
      while (!req_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!req_ready) chk("ready_timeout", 32'd0, 32'd1);
      req_valid = 1'b1;
      req_we = we;
      req_funct3 = f3;
      req_addr = addr;
      req_wdata = wd;
      @(posedge clk);
      #1;
      acc = cyc;
      req_valid = 1'b0;
      req_funct3 = 3'b111;
      req_addr = 32'hFFFF_FFFF;
      req_wdata = 32'h5A5A_5A5A;
      req_we = !we;
      illegal = we ? (f3 > 3'b010) : (f3 == 3'b011 || f3[2:1] == 2'b11);
      sz = f3[1:0];
      mis = (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00);
      mask = (sz == 2'b00) ? 32'hFF : (sz == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
      n = illegal ? 0 : !mis ? 1 : (sz == 2'b01) ? 2 : 4;
      for (int k = 0; k < n && k < keep; k++) begin
         b.addr = addr[AW-1:0] + 17'(k);
         b.we = we;
         if (mis) begin
            sh = wd >> (8 * k);
            b.sz = 2'b01;
            b.wdata = {24'd0, sh[7:0]};
         end else begin
            b.sz = sz + 2'b01;
            b.wdata = wd & mask;
         end
         bq.push_back(b);
      end
      if (do_resp) begin
         r.rdata = exp_rd;
         r.err = exp_err;
         r.cyc = acc + lat - 1;
         rq.push_back(r);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #3;
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_resp", {29'd0, resp_valid, resp_err, ram_ce}, 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_ram_strobes", {26'd0, ram_we, ram_re, ram_wvalid_bit, ram_rvalid_bit}, 32'd0);
      chk("rst_ram_addr", {15'd0, ram_waddr | ram_raddr}, 32'd0);
      chk("rst_ram_wdata", ram_wdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("ram_ce_after_release", {31'd0, ram_ce}, 32'd1);

      //    we  f3      addr           wdata          exp_rdata     err lat keep resp
      issue(1, 3'b010, 32'h0000_0100, 32'hDEADBEEF, 32'h0,        0,  2,  4,  1);
      issue(0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEADBEEF, 0,  2,  4,  1);
      issue(0, 3'b001, 32'h0000_0100, 32'h0,        32'hFFFFBEEF, 0,  2,  4,  1);
      issue(0, 3'b101, 32'h0000_0102, 32'h0,        32'h0000DEAD, 0,  2,  4,  1);
      issue(1, 3'b010, 32'h0000_0101, 32'h11223344, 32'h0,        0,  5,  4,  1);
      issue(0, 3'b010, 32'h0000_0101, 32'h0,        32'h11223344, 0,  5,  4,  1);
      issue(1, 3'b000, 32'h0000_0020, 32'hFFFF_FF80, 32'h0,       0,  2,  4,  1);
      issue(0, 3'b000, 32'h0000_0020, 32'h0,        32'hFFFFFF80, 0,  2,  4,  1);
      issue(0, 3'b100, 32'h0000_0020, 32'h0,        32'h00000080, 0,  2,  4,  1);
      issue(1, 3'b001, 32'h0000_0023, 32'h1234_8001, 32'h0,       0,  3,  4,  1);
      issue(0, 3'b001, 32'h0000_0023, 32'h0,        32'hFFFF8001, 0,  3,  4,  1);
      issue(0, 3'b101, 32'h0000_0023, 32'h0,        32'h00008001, 0,  3,  4,  1);
      issue(0, 3'b011, 32'h0000_0040, 32'h0,        32'h0,        1,  1,  4,  1);
      issue(1, 3'b100, 32'h0000_0040, 32'hCAFEF00D, 32'h0,        1,  1,  4,  1);
      issue(0, 3'b110, 32'h0000_0040, 32'h0,        32'h0,        1,  1,  4,  1);
      issue(1, 3'b010, 32'h0001_FFFE, 32'hAABBCCDD, 32'h0,        0,  5,  4,  1);
      issue(0, 3'b010, 32'h8001_FFFE, 32'h0,        32'hAABBCCDD, 0,  5,  4,  1);
      issue(0, 3'b100, 32'h0000_0000, 32'h0,        32'h000000BB, 0,  2,  4,  1);

      // Reset asserted during the second beat of a misaligned word store.
      issue(1, 3'b010, 32'h0000_0201, 32'h55667788, 32'h0,        0,  5,  1,  0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("midrst_outputs", {26'd0, resp_valid, resp_err, ram_ce, ram_we, ram_re, 1'b0},
          32'd0);
      chk("midrst_ram_bus", {ram_waddr, 11'd0, ram_wvalid_bit, ram_rvalid_bit} | ram_wdata,
          32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
      issue(0, 3'b100, 32'h0000_0201, 32'h0,        32'h00000088, 0,  2,  4,  1);
      issue(0, 3'b100, 32'h0000_0202, 32'h0,        32'h00000000, 0,  2,  4,  1);

      repeat (10) @(negedge clk);
      chk("resp_queue_drained", rq.size(), 32'd0);
      chk("beat_queue_drained", bq.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
